// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-port register file for the CPU datapath.
// Two write ports (ALU and load writeback), NUM_RD combinational read ports,
// optional same-cycle write-to-read bypass, optional hardwired zero register
// and a per-register pending-load scoreboard.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   raddr / rdata     packed read address / data, port i at slice i
//   rbusy             per-port "register awaits a pending load"
//   wren0/waddr0/wdata0  ALU writeback
//   wren1/waddr1/wdata1  load writeback, also clears busy
//   claim_en/claim_addr  marks a register busy when a load issues
module register_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       wren0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       wren1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic                       claim_en,
  input  logic [ADDR_W-1:0]          claim_addr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // True when the address is the hardwired zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  logic wr0_ok, wr1_ok, claim_ok;
  assign wr0_ok   = wren0    && !is_zero(waddr0);
  assign wr1_ok   = wren1    && !is_zero(waddr1);
  assign claim_ok = claim_en && !is_zero(claim_addr);

  // Next state: port 1 write after port 0 so it wins a collision;
  // claim applied after the load clear so it wins a race.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr0_ok) mem_d[waddr0] = wdata0;
    if (wr1_ok) begin
      mem_d[waddr1]  = wdata1;
      busy_d[waddr1] = 1'b0;
    end
    if (claim_ok) busy_d[claim_addr] = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Bypass is gated by rst_n so outputs read zero while reset is held.
  logic byp_en;
  assign byp_en = (BYPASS != 0) && rst_n;

  // Combinational read ports.
  for (genvar gi = 0; gi < int'(NUM_RD); gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0, hit1, zr;
    logic [DATA_W-1:0] rd_c;
    logic              rb_c;

    assign ra   = raddr[gi*ADDR_W +: ADDR_W];
    assign zr   = is_zero(ra);
    assign hit1 = byp_en && wren1 && (waddr1 == ra);
    assign hit0 = byp_en && wren0 && (waddr0 == ra);

    always_comb begin
      rd_c = mem_q[ra];
      rb_c = busy_q[ra];
      if (hit1)      rd_c = wdata1;
      else if (hit0) rd_c = wdata0;
      // Forwarded load data is no longer pending.
      if (hit1) rb_c = 1'b0;
      if (zr) begin
        rd_c = '0;
        rb_c = 1'b0;
      end
    end

    assign rdata[gi*DATA_W +: DATA_W] = rd_c;
    assign rbusy[gi]                  = rb_c;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: one bypassing and one non-bypassing
// instance driven by the same stimulus, with hand-computed expectations.
module tb_register_file_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic              clk;
  logic              rst_n;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata_b, rdata_n;
  logic [NR-1:0]     rbusy_b, rbusy_n;
  logic              wren0, wren1, claim_en;
  logic [AW-1:0]     waddr0, waddr1, claim_addr;
  logic [DW-1:0]     wdata0, wdata1;
  logic [AW-1:0]     ra0, ra1;

  int checks = 0;
  int errors = 0;

  assign raddr = {ra1, ra0};

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .wren0(wren0), .waddr0(waddr0), .wdata0(wdata0),
    .wren1(wren1), .waddr1(waddr1), .wdata1(wdata1),
    .claim_en(claim_en), .claim_addr(claim_addr)
  );

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .wren0(wren0), .waddr0(waddr0), .wdata0(wdata0),
    .wren1(wren1), .waddr1(waddr1), .wdata1(wdata1),
    .claim_en(claim_en), .claim_addr(claim_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wren0 = 1'b0; wren1 = 1'b0; claim_en = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; claim_addr = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ra0 = 5'd5; ra1 = 5'd9;
    #2;
    chk("rst_init_rdata_b", rdata_b[31:0], 32'h0);
    chk("rst_init_rbusy_b", 32'(rbusy_b), 32'h0);
    chk("rst_init_rbusy_n", 32'(rbusy_n), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Preload r5 and claim it.
    wren0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    claim_en = 1'b1; claim_addr = 5'd5;
    ra0 = 5'd5;
    #2;
    chk("preload_byp_b", rdata_b[31:0], 32'hDEADBEEF);
    chk("preload_old_n", rdata_n[31:0], 32'h0);
    cyc();
    idle();
    #2;
    chk("preload_b", rdata_b[31:0], 32'hDEADBEEF);
    chk("preload_n", rdata_n[31:0], 32'hDEADBEEF);
    chk("preload_busy_b", 32'(rbusy_b[0]), 32'h1);

    // Asynchronous reset pulse between edges.
    rst_n = 1'b0;
    #1;
    chk("rst_pulse_rdata_b", rdata_b[31:0], 32'h0);
    chk("rst_pulse_rdata_n", rdata_n[31:0], 32'h0);
    chk("rst_pulse_rbusy_b", 32'(rbusy_b), 32'h0);
    chk("rst_pulse_rbusy_n", 32'(rbusy_n), 32'h0);
    rst_n = 1'b1;
    cyc();

    // Dual-write collision on r7: port 1 wins.
    wren0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    wren1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    ra0 = 5'd7; ra1 = 5'd7;
    #2;
    chk("coll_byp_p0_b", rdata_b[31:0], 32'h22);
    chk("coll_byp_p1_b", rdata_b[63:32], 32'h22);
    chk("coll_old_n", rdata_n[31:0], 32'h0);
    cyc();
    idle();
    #2;
    chk("coll_b", rdata_b[31:0], 32'h22);
    chk("coll_n", rdata_n[63:32], 32'h22);

    // Bypass on r3: preload 1, then overwrite with A5A5A5A5.
    wren0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1;
    ra0 = 5'd3;
    cyc();
    wdata0 = 32'hA5A5A5A5;
    #2;
    chk("byp_new_b", rdata_b[31:0], 32'hA5A5A5A5);
    chk("byp_old_n", rdata_n[31:0], 32'h1);
    cyc();
    idle();
    #2;
    chk("byp_after_n", rdata_n[31:0], 32'hA5A5A5A5);

    // Zero register: writes and claim to r0 dropped.
    wren0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    wren1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    claim_en = 1'b1; claim_addr = 5'd0;
    ra0 = 5'd0; ra1 = 5'd0;
    #2;
    chk("zero_same_b", rdata_b[63:0] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
    chk("zero_same_rbusy_b", 32'(rbusy_b), 32'h0);
    cyc();
    idle();
    #2;
    chk("zero_after_b", rdata_b[31:0], 32'h0);
    chk("zero_after_n", rdata_n[63:32], 32'h0);
    chk("zero_after_rbusy_n", 32'(rbusy_n), 32'h0);

    // Scoreboard on r9.
    claim_en = 1'b1; claim_addr = 5'd9;
    ra0 = 5'd9; ra1 = 5'd9;
    cyc();
    idle();
    #2;
    chk("sb_busy_b", 32'(rbusy_b), 32'h3);
    chk("sb_busy_n", 32'(rbusy_n), 32'h3);
    wren1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h1234;
    #1;
    chk("sb_fwd_rdata_b", rdata_b[31:0], 32'h1234);
    chk("sb_fwd_rbusy_b", 32'(rbusy_b), 32'h0);
    chk("sb_fwd_rbusy_n", 32'(rbusy_n), 32'h3);
    cyc();
    idle();
    #2;
    chk("sb_clr_rbusy_b", 32'(rbusy_b), 32'h0);
    chk("sb_clr_rbusy_n", 32'(rbusy_n), 32'h0);
    chk("sb_clr_rdata_n", rdata_n[31:0], 32'h1234);

    // Claim/clear race on r4: claim wins, data still written.
    claim_en = 1'b1; claim_addr = 5'd4;
    wren1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'hCAFE;
    ra0 = 5'd4; ra1 = 5'd7;
    #2;
    chk("race_fwd_rbusy_b", 32'(rbusy_b), 32'h0);
    cyc();
    idle();
    #2;
    chk("race_rdata_b", rdata_b[31:0], 32'hCAFE);
    chk("race_rdata_n", rdata_n[31:0], 32'hCAFE);
    chk("race_rbusy_b", 32'(rbusy_b), 32'h1);
    chk("race_rbusy_n", 32'(rbusy_n), 32'h1);
    chk("indep_p1_b", rdata_b[63:32], 32'h22);

    // Distinct-address bypass on both ports.
    wren0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h33;
    wren1 = 1'b1; waddr1 = 5'd8; wdata1 = 32'h44;
    ra0 = 5'd7; ra1 = 5'd8;
    #2;
    chk("split_p0_b", rdata_b[31:0], 32'h33);
    chk("split_p1_b", rdata_b[63:32], 32'h44);
    cyc();
    idle();
    #2;
    chk("split_p0_n", rdata_n[31:0], 32'h33);
    chk("split_p1_n", rdata_n[63:32], 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
